avalon_aes_regs: RTL and testbench
==================================

Name: avalon_aes_regs

Overview:
- Avalon-MM slave register file placed between the Nios II bus and the AES decryption core, inside the lab9 SoC component.
- Holds the 128-bit key and encrypted message, launches the core with a start/done handshake, and captures the decrypted result.
- Drives the 32-bit export conduit to the board hex displays: key[127:112] concatenated with key[15:0].

Parameters:
- DATA_W, 32, Avalon data width; fixed by the register map and must stay 32.
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN; used only when AES_TIMEOUT_EN is defined.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- avl_cs  in  1  slave chip select
- avl_read  in  1  read strobe, qualified by avl_cs
- avl_write  in  1  write strobe, qualified by avl_cs
- avl_addr  in  4  word address 0..15
- avl_byte_en  in  4  write byte enables; bit n covers byte n
- avl_writedata  in  32  write data
- avl_readdata  out  32  registered read data
- aes_start  out  1  one-cycle launch pulse to the core
- aes_key  out  128  {reg0,reg1,reg2,reg3}
- aes_msg_en  out  128  {reg4,reg5,reg6,reg7}
- aes_done  in  1  core completion strobe
- aes_msg_de  in  128  decrypted message; valid when aes_done=1
- export_data  out  32  {reg0[31:16], reg3[15:0]}

Behaviour:
- Reset (reset_reset_n=0 at a clock edge):
  - all 16 registers cleared; avl_readdata=0; aes_start=0; FSM=IDLE.
  - Hence aes_key, aes_msg_en and export_data are 0.
  - Reset during RUN abandons the operation; a late aes_done after reset is ignored.
- Register map:
  - 0-3 KEY (R/W)
  - 4-7 MSG_EN (R/W)
  - 8-11 MSG_DE (read-only from the bus)
  - 12-13 scratch (R/W)
  - 14 START (bit0 R/W; other bits read 0)
  - 15 DONE (read-only: bit0 done, bit1 timeout, others 0)
- Writes:
  - Take effect on the edge where avl_cs & avl_write are high.
  - Per-byte merge using avl_byte_en.
  - Writes to 8-11 and 15 are discarded.
  - Writes to 0-7 are discarded while FSM=RUN, so core inputs stay stable.
- Reads:
  - avl_cs & avl_read at edge N puts register data on avl_readdata after edge N (read latency 1).
  - avl_readdata holds its value until the next read.
- FSM IDLE:
  - A write to 14 with byte0 enabled and data bit0=1 sets START=1.
  - aes_start is 1 for exactly the next cycle; the FSM goes to RUN.
- FSM RUN:
  - aes_done=1 captures aes_msg_de into 8-11 (reg8 = bits 127:96) and sets DONE bit0=1; the FSM goes to DONE.
  - aes_done seen in the same cycle as the launch pulse is also accepted.
- FSM DONE:
  - A write of bit0=0 to 14 clears START and DONE[1:0]; the FSM goes to IDLE.
  - Writing START=1 again in DONE only rewrites the bit; it does not relaunch.
- aes_done outside RUN is ignored.
- A simultaneous bus read of 8-11 or 15 on the capture edge returns the pre-capture value.
- export_data is combinational from the registers and follows KEY writes on the next cycle.

Optional Feature:
- Macro: AES_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RUN and increments every RUN cycle.
  - If it reaches TIMEOUT_CYCLES without aes_done, set DONE bit1=1 and DONE bit0=1, leave 8-11 unchanged, and go to DONE.
  - If aes_done and the timeout occur on the same cycle, aes_done wins and bit1 stays 0.
- When undefined: no counter; RUN waits indefinitely; DONE bit1 always reads 0.

Decomposition:
- Package aes_regs_pkg:
  - address constants ADDR_KEY0=0, ADDR_MSG_EN0=4, ADDR_MSG_DE0=8, ADDR_START=14, ADDR_DONE=15
  - state enum {IDLE, RUN, DONE}
  - DONE bit indices
- Sub-module aes_ctrl_fsm contains the FSM, the start pulse, the capture enable and the optional timeout counter.
- The register file and bus decode stay in avalon_aes_regs.

Test Plan:
- Reset, then read every address 0..15 -> each avl_readdata=0 one cycle later; export_data=0.
- Write addr0=0xDEADBEEF with byte_en=0xF and addr3=0x0123CAFE with byte_en=0xF; then write addr0=0x00001111 with byte_en=0x3 -> reg0=0xDEAD1111, export_data=0xDEADCAFE.
- Load KEY/MSG_EN, write addr14=1 -> aes_start high exactly one cycle. Core asserts aes_done 20 cycles later with msg_de=0x00112233_44556677_8899AABB_CCDDEEFF -> addr8..11 read those words, addr15 reads 0x1.
- During RUN, write addr4=0xFFFFFFFF and addr9=0x5 -> both discarded. Then write addr14=0 after DONE -> addr15=0, FSM IDLE, aes_done pulse now ignored.
- Launch, then reset_reset_n=0 for one cycle mid-RUN, then aes_done=1 -> all regs 0, no capture, aes_start=0.
- With AES_TIMEOUT_EN and TIMEOUT_CYCLES=8, launch with no aes_done -> after 8 RUN cycles addr15=0x3, MSG_DE unchanged.

Source files
------------

// File: rtl/aes_regs_pkg.sv
// Shared constants and types for the Avalon AES register block.
// Optional AES_TIMEOUT_EN adds a RUN-state watchdog in aes_ctrl_fsm.
package aes_regs_pkg;

  localparam logic [3:0] ADDR_KEY0     = 4'd0;
  localparam logic [3:0] ADDR_MSG_EN0  = 4'd4;
  localparam logic [3:0] ADDR_MSG_DE0  = 4'd8;
  localparam logic [3:0] ADDR_SCRATCH0 = 4'd12;
  localparam logic [3:0] ADDR_SCRATCH1 = 4'd13;
  localparam logic [3:0] ADDR_START    = 4'd14;
  localparam logic [3:0] ADDR_DONE     = 4'd15;

  localparam int unsigned DONE_BIT    = 0;
  localparam int unsigned TIMEOUT_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byte_en);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/aes_ctrl_fsm.sv
// Launch/complete handshake with the AES core: start pulse, capture enable, DONE flags.
// With AES_TIMEOUT_EN defined, RUN is abandoned after TIMEOUT_CYCLES cycles.
module aes_ctrl_fsm
  import aes_regs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   launch_req,
  input  logic   clear_req,
  input  logic   aes_done,
  output state_t state,
  output logic   aes_start,
  output logic   capture,
  output logic   done_flag,
  output logic   timeout_flag
);

  // NOTE: capture is combinational so the result lands on the same edge the core strobes done.
  always_comb capture = (state == RUN) && aes_done;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt;
  logic             timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN) timeout_cnt <= '0;
    else                        timeout_cnt <= timeout_cnt + 1'b1;
  end

  assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      aes_start    <= 1'b0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      unique case (state)
        IDLE: if (launch_req) begin
          state     <= RUN;
          aes_start <= 1'b1;
        end
        RUN: if (aes_done) begin
          state     <= DONE;
          done_flag <= 1'b1;
        end else if (timeout_hit) begin
          state        <= DONE;
          done_flag    <= 1'b1;
          timeout_flag <= 1'b1;
        end
        DONE: if (clear_req) begin
          state        <= IDLE;
          done_flag    <= 1'b0;
          timeout_flag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/avalon_aes_regs.sv
// Avalon-MM register file fronting the AES decryption core, with hex-display export.
// Define AES_TIMEOUT_EN to enable the RUN-state watchdog (DONE bit1).
module avalon_aes_regs
  import aes_regs_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              avl_cs,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [3:0]        avl_addr,
  input  logic [3:0]        avl_byte_en,
  input  logic [DATA_W-1:0] avl_writedata,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              aes_start,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_msg_en,
  input  logic              aes_done,
  input  logic [127:0]      aes_msg_de,
  output logic [31:0]       export_data
);

  logic [DATA_W-1:0] regs [0:13];
  logic              start_bit;
  logic              wr_en, rd_en, start_wr;
  logic              capture, done_flag, timeout_flag;
  state_t            state;
  logic [DATA_W-1:0] rd_word;

  assign wr_en    = avl_cs && avl_write;
  assign rd_en    = avl_cs && avl_read;
  assign start_wr = wr_en && (avl_addr == ADDR_START) && avl_byte_en[0];

  aes_ctrl_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk          (clk_clk),
    .rst_n        (reset_reset_n),
    .launch_req   (start_wr && avl_writedata[0]),
    .clear_req    (start_wr && !avl_writedata[0]),
    .aes_done     (aes_done),
    .state        (state),
    .aes_start    (aes_start),
    .capture      (capture),
    .done_flag    (done_flag),
    .timeout_flag (timeout_flag)
  );

  always_comb begin
    rd_word = '0;
    if (avl_addr <= ADDR_SCRATCH1)   rd_word = regs[avl_addr];
    else if (avl_addr == ADDR_START) rd_word[0] = start_bit;
    else begin
      rd_word[DONE_BIT]    = done_flag;
      rd_word[TIMEOUT_BIT] = timeout_flag;
    end
  end

  // NOTE: the register file is reset word by word because software expects all-zero after reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 14; i++) regs[i] <= '0;
      start_bit    <= 1'b0;
      avl_readdata <= '0;
    end else begin
      if (wr_en) begin
        // Core inputs are frozen while the core is running.
        if ((avl_addr < ADDR_MSG_DE0 && state != RUN) ||
            avl_addr == ADDR_SCRATCH0 || avl_addr == ADDR_SCRATCH1)
          regs[avl_addr] <= merge_bytes(regs[avl_addr], avl_writedata, avl_byte_en);
        else if (start_wr)
          start_bit <= avl_writedata[0];
      end
      if (capture) begin
        for (int i = 0; i < 4; i++)
          regs[int'(ADDR_MSG_DE0) + i] <= aes_msg_de[127 - 32*i -: 32];
      end
      if (rd_en) avl_readdata <= rd_word;
    end
  end

  assign aes_key     = {regs[0], regs[1], regs[2], regs[3]};
  assign aes_msg_en  = {regs[4], regs[5], regs[6], regs[7]};
  assign export_data = {regs[0][31:16], regs[3][15:0]};

endmodule

// File: tb/tb_avalon_aes_regs.sv
// Self-checking bench for avalon_aes_regs: directed scenarios plus random bus/core traffic.
// Define AES_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_avalon_aes_regs;

  localparam int TO = 8;
`ifdef AES_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]   addr = '0, be = '0;
  logic [31:0]  wd = '0;
  logic [31:0]  readdata;
  logic         start;
  logic [127:0] key, msg_en;
  logic         done = 1'b0;
  logic [127:0] msg_de = '0;
  logic [31:0]  export_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  avalon_aes_regs #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avl_cs        (cs),
    .avl_read      (rd),
    .avl_write     (wr),
    .avl_addr      (addr),
    .avl_byte_en   (be),
    .avl_writedata (wd),
    .avl_readdata  (readdata),
    .aes_start     (start),
    .aes_key       (key),
    .aes_msg_en    (msg_en),
    .aes_done      (done),
    .aes_msg_de    (msg_de),
    .export_data   (export_data)
  );

  // Reference model: the sixteen words as software sees them, plus the operation phase.
  logic [31:0] m_reg [16];
  logic [31:0] m_rd;
  bit          m_pulse, m_busy, m_finished;
  int          m_run_cycles;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit busy0, fin0;
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_rd = '0; m_pulse = 0; m_busy = 0; m_finished = 0; m_run_cycles = 0;
      return;
    end
    busy0 = m_busy;
    fin0  = m_finished;
    m_pulse = 0;
    if (cs && rd) m_rd = m_reg[addr];
    if (cs && wr) begin
      if ((addr <= 7 && !busy0) || addr == 12 || addr == 13)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_reg[addr][8*b +: 8] = wd[8*b +: 8];
      if (addr == 14 && be[0]) begin
        m_reg[14] = {31'b0, wd[0]};
        if (!busy0 && !fin0 && wd[0]) begin
          m_busy = 1; m_pulse = 1; m_run_cycles = 0;
        end
        if (fin0 && !wd[0]) begin
          m_finished = 0; m_reg[15] = 0;
        end
      end
    end
    if (busy0) begin
      if (done) begin
        for (int w = 0; w < 4; w++) m_reg[8 + w] = msg_de[127 - 32*w -: 32];
        m_reg[15] = 32'h1; m_busy = 0; m_finished = 1;
      end else if (TO_EN) begin
        m_run_cycles++;
        if (m_run_cycles == TO) begin
          m_reg[15] = 32'h3; m_busy = 0; m_finished = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("readdata", readdata, m_rd);
    check("aes_start", start, m_pulse);
    check("export", export_data, {m_reg[0][31:16], m_reg[3][15:0]});
    check("aes_key", key, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
    check("aes_msg_en", msg_en, {m_reg[4], m_reg[5], m_reg[6], m_reg[7]});
  endtask

  task automatic drive(input bit c, input bit r, input bit w, input logic [3:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit dn,
                       input logic [127:0] m);
    cs = c; rd = r; wr = w; addr = a; be = b; wd = d; done = dn; msg_de = m;
    tick();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1, 0, 1, a, b, d, 0, '0);
  endtask

  task automatic read_reg(input logic [3:0] a);
    drive(1, 1, 0, a, 4'h0, '0, 0, '0);
  endtask

  task automatic idle(input bit dn, input logic [127:0] m);
    drive(0, 0, 0, 4'h0, 4'h0, '0, dn, m);
  endtask

  localparam logic [127:0] MSG = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    logic [31:0] words [4];
    int          delay;
    words = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    delay = TO_EN ? 5 : 20;

    rst_n = 1'b0;
    idle(0, '0);
    idle(0, '0);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      read_reg(4'(a));
      check("reset_read", readdata, 32'h0);
    end
    check("reset_export", export_data, 32'h0);

    write_reg(4'd0, 32'hDEADBEEF, 4'hF);
    write_reg(4'd3, 32'h0123CAFE, 4'hF);
    write_reg(4'd0, 32'h00001111, 4'h3);
    read_reg(4'd0);
    check("byte_merge", readdata, 32'hDEAD1111);
    check("export_mix", export_data, 32'hDEADCAFE);

    for (int a = 1; a < 8; a++) write_reg(4'(a), $urandom, 4'hF);
    write_reg(4'd14, 32'h1, 4'h1);
    check("launch_pulse", start, 1'b1);
    idle(0, '0);
    check("pulse_one_cycle", start, 1'b0);
    for (int i = 0; i < delay - 2; i++) idle(0, '0);
    idle(1, MSG);
    for (int w = 0; w < 4; w++) begin
      read_reg(4'(8 + w));
      check("msg_de_word", readdata, words[w]);
    end
    read_reg(4'd15);
    check("done_flag", readdata, 32'h1);

    write_reg(4'd14, 32'h0, 4'h1);
    write_reg(4'd4, 32'h13572468, 4'hF);
    write_reg(4'd14, 32'h1, 4'h1);
    write_reg(4'd4, 32'hFFFFFFFF, 4'hF);
    write_reg(4'd9, 32'h5, 4'hF);
    idle(1, MSG);
    read_reg(4'd4);
    check("run_write_lock", readdata, 32'h13572468);
    read_reg(4'd9);
    check("msg_de_readonly", readdata, 32'h44556677);
    write_reg(4'd14, 32'h0, 4'h1);
    read_reg(4'd15);
    check("done_cleared", readdata, 32'h0);
    idle(1, ~MSG);
    read_reg(4'd8);
    check("idle_done_ignored", readdata, 32'h00112233);

    write_reg(4'd14, 32'h1, 4'h1);
    idle(0, '0);
    rst_n = 1'b0;
    idle(0, '0);
    rst_n = 1'b1;
    idle(1, MSG);
    check("reset_key", key, 128'h0);
    check("reset_start", start, 1'b0);
    read_reg(4'd8);
    check("reset_no_capture", readdata, 32'h0);

    write_reg(4'd8, 32'hA5A5A5A5, 4'hF);
    write_reg(4'd14, 32'h1, 4'h1);
    for (int i = 0; i < 30; i++) idle(0, '0);
    read_reg(4'd15);
`ifdef AES_TIMEOUT_EN
    check("timeout_done", readdata, 32'h3);
`else
    check("no_timeout", readdata, 32'h0);
`endif
    read_reg(4'd8);
    check("timeout_msg_kept", readdata, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [31:0] d;
      logic [127:0] m;
      r = $urandom_range(0, 99);
      d = $urandom;
      m = {$urandom, $urandom, $urandom, $urandom};
      rst_n = ($urandom_range(0, 299) != 0);
      if (r < 40)
        drive(1, 1, 0, 4'($urandom_range(0, 15)), 4'h0, d, ($urandom_range(0, 7) == 0), m);
      else if (r < 72)
        drive(1, 0, 1, 4'($urandom_range(0, 15)), 4'($urandom), d, ($urandom_range(0, 7) == 0), m);
      else if (r < 84)
        drive(1, 0, 1, 4'd14, 4'($urandom) | 4'h1, d | 32'h1, ($urandom_range(0, 7) == 0), m);
      else if (r < 92)
        drive(1, 0, 1, 4'd14, 4'($urandom) | 4'h1, d & ~32'h1, ($urandom_range(0, 7) == 0), m);
      else
        drive(0, 1, 1, 4'($urandom), 4'($urandom), d, ($urandom_range(0, 3) == 0), m);
    end
    rst_n = 1'b1;
    idle(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
